dmem_stream_reader: RTL

- Read-side DMA engine for the four-bank data memory (4 x 64K words).
- Given a base word address and word count, it issues sequential reads and streams each word out over a valid/ready interface, with a last-word flag.
- Drains decrypted RSA plaintext from data memory toward an output sink (UART/display bridge) without processor involvement.
- Absorbs the memory's one-cycle read latency and sink back-pressure using a 2-entry output FIFO.

---
 rtl/dmem_stream_reader_if.sv | 23 ++
 rtl/dmem_stream_reader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dmem_stream_reader_if.sv
// Memory read port and output stream of the data-memory stream reader.
// The master side is the reader; the slave side is the memory plus the sink.
interface dmem_stream_reader_if #(
  parameter int N = 32
);
  logic         mem_read_en;
  logic [N-1:0] mem_address;
  logic [N-1:0] mem_read_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_last;

  modport master (
    output mem_read_en, mem_address, out_valid, out_data, out_last,
    input  mem_read_data, out_ready
  );

  modport slave (
    input  mem_read_en, mem_address, out_valid, out_data, out_last,
    output mem_read_data, out_ready
  );
endinterface

// File: rtl/dmem_stream_reader.sv
// Read-side DMA: range-checks a (base, count) request, then issues sequential reads
// across the four data-memory banks and streams the words through a 2-entry FIFO.
module dmem_stream_reader #(
  parameter int N         = 32,
  parameter int ADDR_STEP = 1,
  parameter int MAX_BANK  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          base_addr,
  input  logic [15:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  range_error,
  dmem_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_READ, S_DRAIN} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [15:0]  issue_q, issue_d;
  logic         inflight_q, inflight_d;
  logic         inflight_last_q, inflight_last_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         rerr_q, rerr_d;

  logic [N-1:0] fifo_data_q [2];
  logic         fifo_last_q [2];

  logic [N+15:0] end_addr;
  logic          bad_range;
  logic          push, pop, rd_en, head_last;
  logic [2:0]    credit;

  // End address is formed 16 bits wider than the address so a wrap past 2^N is seen.
  assign end_addr  = (N+16)'(addr_q) + (N+16)'(issue_q - 16'd1) * (N+16)'(ADDR_STEP);
  assign bad_range = (|end_addr[N+15:N]) || (end_addr[N-1:16] > (N-16)'(MAX_BANK));

  assign push      = inflight_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign pop       = bus.out_valid && bus.out_ready;
  assign head_last = fifo_last_q[rd_ptr_q];

  // Entries still owed to the FIFO once this cycle's pop retires; a new read adds one.
  assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en  = (state_q == S_READ) && (issue_q != 16'd0) && (credit < 3'd2);

  assign bus.mem_read_en = rd_en;
  assign bus.mem_address = addr_q;
  assign bus.out_data    = bus.out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.out_last    = bus.out_valid && head_last;

  assign busy        = busy_q;
  assign done        = done_q;
  assign range_error = rerr_q;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    issue_d         = issue_q;
    done_d          = 1'b0;
    rerr_d          = 1'b0;
    inflight_d      = rd_en;
    inflight_last_d = rd_en && (issue_q == 16'd1);
    wr_ptr_d        = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d        = pop  ? ~rd_ptr_q : rd_ptr_q;
    occ_d           = occ_q + 2'(push) - 2'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          issue_d = word_count;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (issue_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (bad_range) begin
          rerr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_en) begin
          addr_d  = addr_q + N'(ADDR_STEP);
          issue_d = issue_q - 16'd1;
          if (issue_q == 16'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Popping the tagged word means every read has been issued and delivered.
        if (pop && head_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      issue_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rerr_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      issue_q         <= issue_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      rerr_q          <= rerr_d;
    end
  end

  // FIFO storage carries no reset; out_data is masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.mem_read_data;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

endmodule
